prefetch_unit: RTL

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prefetch_unit.sv
// prefetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry queue.
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module prefetch_unit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   IW       = 16,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   INC      = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [IW-1:0]          imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [IW-1:0]          inst_out,
  output logic [AW-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] INC_MASK = AW'(INC - 1);
  localparam logic [AW:0]   INC_W    = (AW+1)'(INC);

  // FS_DROP: a request is still in flight but its response belongs to a flushed stream.
  typedef enum logic [1:0] {
    FS_IDLE,
    FS_BUSY,
    FS_DROP
  } fetch_state_t;

  fetch_state_t  r_fstate;
  fetch_state_t  w_fstate_nxt;

  logic [IW-1:0] r_q_data [DEPTH];
  logic [AW-1:0] r_q_pc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_tag;
  logic          r_err;

  logic          w_resp_keep;
  logic          w_free;
  logic [CW:0]   w_occ;
  logic          w_acc;
  logic [AW:0]   w_pc_sum;
  logic          w_misalign;
  logic          w_head_valid;
  logic          w_byp;
  logic          w_pop;
  logic          w_push;

  always_comb begin
    w_resp_keep  = imem_rvalid & (r_fstate == FS_BUSY);
    // A kept response frees the single slot this cycle; a dropped one frees it next cycle.
    w_free       = (r_fstate == FS_IDLE) | w_resp_keep;
    w_occ        = {1'b0, r_count} + {{CW{1'b0}}, (r_fstate != FS_IDLE)};
    imem_req     = rst & w_free & (w_occ < DEPTH_W) & ~halt & ~redirect & ~r_err;
    w_acc        = imem_req & imem_gnt;
    w_pc_sum     = {1'b0, r_pc} + INC_W;
    w_misalign   = (redirect_pc & INC_MASK) != '0;
    w_head_valid = r_count != '0;
`ifdef PREFETCH_BYPASS_EN
    w_byp        = ~w_head_valid & w_resp_keep & ~redirect;
`else
    w_byp        = 1'b0;
`endif
    w_pop        = w_head_valid & inst_ready & ~redirect;
    w_push       = w_resp_keep & ~redirect & ~(w_byp & inst_ready);
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    case (r_fstate)
      FS_IDLE: begin
        if (w_acc) w_fstate_nxt = FS_BUSY;
      end
      FS_BUSY: begin
        if (imem_rvalid)   w_fstate_nxt = w_acc ? FS_BUSY : FS_IDLE;
        else if (redirect) w_fstate_nxt = FS_DROP;
      end
      FS_DROP: begin
        if (imem_rvalid) w_fstate_nxt = FS_IDLE;
      end
      default: w_fstate_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fstate <= FS_IDLE;
    end else begin
      r_fstate <= w_fstate_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_PC;
      r_tag <= '0;
      r_err <= 1'b0;
    end else if (redirect) begin
      r_pc <= redirect_pc;
      if (w_misalign) r_err <= 1'b1;
    end else if (w_acc) begin
      r_pc  <= w_pc_sum[AW-1:0];
      r_tag <= r_pc;
      if (w_pc_sum[AW]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= imem_rdata;
      r_q_pc[r_wptr]   <= r_tag;
    end
  end

  always_comb begin
    imem_addr  = r_pc;
    count      = r_count;
    err        = r_err;
    inst_valid = w_head_valid | w_byp;
`ifdef PREFETCH_BYPASS_EN
    inst_out   = w_head_valid ? r_q_data[r_rptr] : imem_rdata;
    inst_pc    = w_head_valid ? r_q_pc[r_rptr]   : r_tag;
`else
    inst_out   = r_q_data[r_rptr];
    inst_pc    = r_q_pc[r_rptr];
`endif
  end

endmodule
